// File: rtl/seq_mag_comp.sv
// seq_mag_comp: handshaked, bit-serial magnitude/equality comparator.
// Operands are latched from a valid/ready port, then scanned MSB-first one
// bit per cycle, stopping at the first differing bit. The mode-selected
// result is returned on a valid/ready port. Saturating counters track
// delivered results and matching results.
module seq_mag_comp #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             match,
    output logic             a_lt_b,
    output logic             a_gt_b,
    input  logic             clear,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] MODE_EQ = 2'b00;
    localparam logic [1:0] MODE_NE = 2'b01;
    localparam logic [1:0] MODE_LT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       mode_r;
    logic [IDX_W-1:0] idx;

    logic accept;
    logic deliver;
    logic bit_a;
    logic bit_b;
    logic scan_end;
    logic gt_nxt;
    logic lt_nxt;
    logic match_nxt;

    // Handshakes are qualified by registered state only, so the ready/valid
    // outputs never depend combinationally on in_valid or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    // Current bit pair under inspection; the scan ends on a difference or at bit 0.
    assign bit_a    = a_r[idx];
    assign bit_b    = b_r[idx];
    assign scan_end = (bit_a != bit_b) || (idx == '0);
    assign gt_nxt   = bit_a & ~bit_b;
    assign lt_nxt   = ~bit_a & bit_b;

    // Result selection from the latched mode and the flags about to be stored.
    always_comb begin
        match_nxt = 1'b0;
        case (mode_r)
            MODE_EQ: match_nxt = ~lt_nxt & ~gt_nxt;
            MODE_NE: match_nxt = lt_nxt | gt_nxt;
            MODE_LT: match_nxt = lt_nxt;
            default: match_nxt = gt_nxt;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> SCAN on accept, SCAN -> DONE at scan end,
    // DONE -> IDLE on delivery.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = SCAN;
            SCAN:    if (scan_end) state_nxt = DONE;
            DONE:    if (deliver)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and MSB-first bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= MODE_EQ;
            idx    <= '0;
        end else if (accept) begin
            a_r    <= data_a;
            b_r    <= data_b;
            mode_r <= mode;
            idx    <= IDX_W'(WIDTH - 1);
        end else if (state == SCAN && !scan_end) begin
            idx    <= idx - 1'b1;
        end
    end

    // Result flags: written once at scan end, then frozen through DONE
    // (including backpressure) and beyond until the next scan completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match  <= 1'b0;
            a_lt_b <= 1'b0;
            a_gt_b <= 1'b0;
        end else if (state == SCAN && scan_end) begin
            match  <= match_nxt;
            a_lt_b <= lt_nxt;
            a_gt_b <= gt_nxt;
        end
    end

    // Saturating statistics; clear takes priority over a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt <= '0;
            hit_cnt   <= '0;
        end else if (clear) begin
            total_cnt <= '0;
            hit_cnt   <= '0;
        end else if (deliver) begin
            if (total_cnt != '1)         total_cnt <= total_cnt + 1'b1;
            if (match && hit_cnt != '1)  hit_cnt   <= hit_cnt + 1'b1;
        end
    end

endmodule
